// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU control codes, RV32I opcodes and funct3 decode helper
package alu_pkg;

  localparam logic [3:0] ALU_CTRL_AND  = 4'b0000;
  localparam logic [3:0] ALU_CTRL_OR   = 4'b0001;
  localparam logic [3:0] ALU_CTRL_ADD  = 4'b0010;
  localparam logic [3:0] ALU_CTRL_SLL  = 4'b0011;
  localparam logic [3:0] ALU_CTRL_SLTU = 4'b0100;
  localparam logic [3:0] ALU_CTRL_SLT  = 4'b0101;
  localparam logic [3:0] ALU_CTRL_SUB  = 4'b0110;
  localparam logic [3:0] ALU_CTRL_XOR  = 4'b0111;
  localparam logic [3:0] ALU_CTRL_SRL  = 4'b1000;
  localparam logic [3:0] ALU_CTRL_SRA  = 4'b1010;
  localparam logic [3:0] ALU_CTRL_NOP  = 4'b1111;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [31:0] NOP_INST = 32'h00000013;

  // Shared by R-type and I-type; immediates never encode sub, so allow_sub gates inst[30] on 000.
  function automatic logic [3:0] funct3_ctrl(input logic [2:0] funct3, input logic alt,
                                             input logic allow_sub);
    logic [3:0] ctrl;
    case (funct3)
      3'b000:  ctrl = (alt && allow_sub) ? ALU_CTRL_SUB : ALU_CTRL_ADD;
      3'b001:  ctrl = ALU_CTRL_SLL;
      3'b010:  ctrl = ALU_CTRL_SLT;
      3'b011:  ctrl = ALU_CTRL_SLTU;
      3'b100:  ctrl = ALU_CTRL_XOR;
      3'b101:  ctrl = alt ? ALU_CTRL_SRA : ALU_CTRL_SRL;
      3'b110:  ctrl = ALU_CTRL_OR;
      default: ctrl = ALU_CTRL_AND;
    endcase
    return ctrl;
  endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// rtl/alu_issue_decode.sv - combinational RV32I decode to ALU control and operands
// Optional illegal-encoding flag under ALU_ISSUE_ILLEGAL_TRAP_EN.
module alu_issue_decode
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [31:0]  inst,
  input  logic [N-1:0] rs1_data,
  input  logic [N-1:0] rs2_data,
  output logic [3:0]   alu_ctrl,
  output logic [N-1:0] op_a,
  output logic [N-1:0] op_b
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
  ,
  output logic         illegal
`endif
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       alt;
  logic       is_shift;

  assign opcode   = inst[6:0];
  assign funct3   = inst[14:12];
  assign alt      = inst[30];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  // Sign-extend a 32-bit value from bit 31 to the operand width.
  function automatic logic [N-1:0] sext32(input logic [31:0] v);
    return N'($signed(v));
  endfunction

  always_comb begin
    alu_ctrl = ALU_CTRL_NOP;
    op_a     = rs1_data;
    op_b     = '0;
    case (opcode)
      OPC_RTYPE: begin
        alu_ctrl = funct3_ctrl(funct3, alt, 1'b1);
        op_b     = rs2_data;
      end
      OPC_ITYPE: begin
        alu_ctrl = funct3_ctrl(funct3, alt, 1'b0);
        op_b     = is_shift ? N'(inst[24:20]) : sext32({{20{inst[31]}}, inst[31:20]});
      end
      OPC_LOAD: begin
        alu_ctrl = ALU_CTRL_ADD;
        op_b     = sext32({{20{inst[31]}}, inst[31:20]});
      end
      OPC_STORE: begin
        alu_ctrl = ALU_CTRL_ADD;
        op_b     = sext32({{20{inst[31]}}, inst[31:25], inst[11:7]});
      end
      OPC_BRANCH: begin
        alu_ctrl = ALU_CTRL_SUB;
        op_b     = rs2_data;
      end
      OPC_LUI: begin
        alu_ctrl = ALU_CTRL_ADD;
        op_a     = '0;
        op_b     = sext32({inst[31:12], 12'b0});
      end
      default: begin
        alu_ctrl = ALU_CTRL_NOP;
        op_a     = '0;
        op_b     = '0;
      end
    endcase
  end

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
  always_comb begin
    illegal = 1'b0;
    case (opcode)
      OPC_RTYPE: begin
        if ((inst[31:25] != 7'b0000000) && (inst[31:25] != 7'b0100000))
          illegal = 1'b1;
        if (alt && (funct3 != 3'b000) && (funct3 != 3'b101))
          illegal = 1'b1;
      end
      OPC_ITYPE, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_LUI: illegal = 1'b0;
      default: illegal = 1'b1;
    endcase
  end
`endif

endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - registered issue stage with 2-entry skid buffer toward the ALU
// Optional out_illegal/illegal_seen ports under ALU_ISSUE_ILLEGAL_TRAP_EN.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int N     = 32,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_inst,
  input  logic [N-1:0] in_rs1_data,
  input  logic [N-1:0] in_rs2_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [3:0]   out_alu_ctrl,
  output logic [N-1:0] out_op_a,
  output logic [N-1:0] out_op_b,
  output logic [31:0]  out_inst
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
  ,
  output logic         out_illegal,
  output logic         illegal_seen
`endif
);

  if (DEPTH != 2) begin : g_bad_depth
    $error("alu_issue_stage: only DEPTH=2 is supported");
  end

  logic [3:0]   dec_ctrl;
  logic [N-1:0] dec_a;
  logic [N-1:0] dec_b;
  logic         dec_illegal;

  alu_issue_decode #(.N(N)) u_decode (
    .inst     (in_inst),
    .rs1_data (in_rs1_data),
    .rs2_data (in_rs2_data),
    .alu_ctrl (dec_ctrl),
    .op_a     (dec_a),
    .op_b     (dec_b)
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    ,
    .illegal  (dec_illegal)
`endif
  );

`ifndef ALU_ISSUE_ILLEGAL_TRAP_EN
  assign dec_illegal = 1'b0;
`endif

  logic [1:0] count;
  logic       push;
  logic       pop;
  logic       load_head;
  logic       load_tail;
  logic       shift;

  // The output registers are the head slot; the tail slot only fills under backpressure.
  logic [3:0]   tail_ctrl;
  logic [N-1:0] tail_a;
  logic [N-1:0] tail_b;
  logic [31:0]  tail_inst;
  logic         tail_illegal;
  logic         head_illegal;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // count==2 blocks push, so push&pop only happens at count==1 and replaces the head.
  assign load_head = push && ((count == 2'd0) || pop);
  assign load_tail = push && !pop && (count == 2'd1);
  assign shift     = pop && (count == 2'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      count        <= 2'd0;
      out_alu_ctrl <= ALU_CTRL_NOP;
      out_op_a     <= '0;
      out_op_b     <= '0;
      out_inst     <= NOP_INST;
      head_illegal <= 1'b0;
      tail_ctrl    <= ALU_CTRL_NOP;
      tail_a       <= '0;
      tail_b       <= '0;
      tail_inst    <= NOP_INST;
      tail_illegal <= 1'b0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      if (push && !pop)
        count <= count + 2'd1;
      else if (pop && !push)
        count <= count - 2'd1;

      if (load_head) begin
        out_alu_ctrl <= dec_ctrl;
        out_op_a     <= dec_a;
        out_op_b     <= dec_b;
        out_inst     <= in_inst;
        head_illegal <= dec_illegal;
      end else if (shift) begin
        out_alu_ctrl <= tail_ctrl;
        out_op_a     <= tail_a;
        out_op_b     <= tail_b;
        out_inst     <= tail_inst;
        head_illegal <= tail_illegal;
      end

      if (load_tail) begin
        tail_ctrl    <= dec_ctrl;
        tail_a       <= dec_a;
        tail_b       <= dec_b;
        tail_inst    <= in_inst;
        tail_illegal <= dec_illegal;
      end
    end
  end

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
  assign out_illegal = head_illegal;

  // Sticky across flush; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst)
      illegal_seen <= 1'b0;
    else if (push && !flush && dec_illegal)
      illegal_seen <= 1'b1;
  end
`else
  logic unused_illegal;
  assign unused_illegal = head_illegal ^ tail_illegal;
`endif

endmodule
